// File: rtl/ex_trig_pkg.sv
// Shared types and default constants for the external-trigger gate.
// The optional timestamp output is controlled by the EX_TRIG_TIMESTAMP_EN macro.
package ex_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_e;

  localparam int DEF_PULSE_CYCLES   = 4;
  localparam int DEF_HOLDOFF_CYCLES = 80;
  localparam int DEF_ID_W           = 16;
  localparam int DEF_CNT_W          = 32;
  localparam int TSTAMP_W           = 32;
  // Shared down-counter for the PULSE and HOLDOFF states.
  localparam int TMR_W              = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import ex_trig_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up until all-ones, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/ex_trig_gate.sv
// Gates the stretched external trigger into a fixed-width ASIC trigger with holdoff,
// an ID handshake and saturating counters. Define EX_TRIG_TIMESTAMP_EN for Out_Trig_Tstamp.
module ex_trig_gate
  import ex_trig_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int ID_W           = DEF_ID_W,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic             In_Ex_Trig,
  input  logic             In_Trig_En,
  input  logic             In_Busy,
  input  logic             In_Cnt_Clr,
  input  logic             In_Trig_Id_Ready,
  output logic             Out_Asic_Trig,
  output logic [ID_W-1:0]  Out_Trig_Id,
  output logic             Out_Trig_Id_Valid,
  output logic [CNT_W-1:0] Out_Acc_Cnt,
  output logic [CNT_W-1:0] Out_Rej_Cnt
`ifdef EX_TRIG_TIMESTAMP_EN
  ,
  output logic [TSTAMP_W-1:0] Out_Trig_Tstamp
`endif
);

  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLDOFF_CYCLES - 1);

  trig_state_e       state_r;
  logic [TMR_W-1:0]  timer_r;
  logic              trig_q_r;
  logic [ID_W-1:0]   next_id_r;
  logic              edge_s;
  logic              accept_s;
  logic              reject_s;

  always_comb begin
    edge_s   = In_Ex_Trig & ~trig_q_r;
    accept_s = edge_s & In_Trig_En & ~In_Busy & (state_r == IDLE) &
               ~Out_Trig_Id_Valid & ~In_Cnt_Clr;
    reject_s = edge_s & In_Trig_En & ~In_Cnt_Clr & ~accept_s;
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      trig_q_r <= 1'b0;
    end else begin
      trig_q_r <= In_Ex_Trig;
    end
  end

  // Timed states run to completion regardless of enable or busy.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_r       <= IDLE;
      timer_r       <= {TMR_W{1'b0}};
      Out_Asic_Trig <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r       <= PULSE;
            timer_r       <= PULSE_LOAD;
            Out_Asic_Trig <= 1'b1;
          end else begin
            Out_Asic_Trig <= 1'b0;
          end
        end
        PULSE: begin
          if (timer_r == {TMR_W{1'b0}}) begin
            Out_Asic_Trig <= 1'b0;
            if (HOLDOFF_CYCLES == 0) begin
              state_r <= IDLE;
            end else begin
              state_r <= HOLDOFF;
              timer_r <= HOLD_LOAD;
            end
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        HOLDOFF: begin
          if (timer_r == {TMR_W{1'b0}}) begin
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        default: begin
          state_r       <= IDLE;
          timer_r       <= {TMR_W{1'b0}};
          Out_Asic_Trig <= 1'b0;
        end
      endcase
    end
  end

  // One ID outstanding at a time; the clear only touches the next ID, not a pending one.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      Out_Trig_Id_Valid <= 1'b0;
      Out_Trig_Id       <= {ID_W{1'b0}};
      next_id_r         <= {ID_W{1'b0}};
    end else begin
      if (accept_s) begin
        Out_Trig_Id_Valid <= 1'b1;
        Out_Trig_Id       <= next_id_r;
      end else if (Out_Trig_Id_Valid && In_Trig_Id_Ready) begin
        Out_Trig_Id_Valid <= 1'b0;
      end else begin
        Out_Trig_Id_Valid <= Out_Trig_Id_Valid;
      end
      if (In_Cnt_Clr) begin
        next_id_r <= {ID_W{1'b0}};
      end else if (accept_s) begin
        next_id_r <= next_id_r + ID_W'(1);
      end else begin
        next_id_r <= next_id_r;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk   (Clk),
    .rst_n (Rst_N),
    .inc   (accept_s),
    .clr   (In_Cnt_Clr),
    .cnt   (Out_Acc_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_rej_cnt (
    .clk   (Clk),
    .rst_n (Rst_N),
    .inc   (reject_s),
    .clr   (In_Cnt_Clr),
    .cnt   (Out_Rej_Cnt)
  );

`ifdef EX_TRIG_TIMESTAMP_EN
  logic [TSTAMP_W-1:0] ts_cnt_r;

  // Free-running time base, latched into the output on accept.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      ts_cnt_r        <= {TSTAMP_W{1'b0}};
      Out_Trig_Tstamp <= {TSTAMP_W{1'b0}};
    end else begin
      if (In_Cnt_Clr) begin
        ts_cnt_r <= {TSTAMP_W{1'b0}};
      end else begin
        ts_cnt_r <= ts_cnt_r + TSTAMP_W'(1);
      end
      if (accept_s) begin
        Out_Trig_Tstamp <= ts_cnt_r;
      end else begin
        Out_Trig_Tstamp <= Out_Trig_Tstamp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_trig_gate.sv
// Directed bench for ex_trig_gate: a cycle-time model checked every cycle plus literal checks.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_ex_trig_gate;

  localparam int P = 4;
  localparam int H = 80;

  logic Clk, Rst_N, In_Ex_Trig, In_Trig_En, In_Busy, In_Cnt_Clr, In_Trig_Id_Ready;
  logic        asic, valid, asic4, valid4;
  logic [15:0] id, id4;
  logic [31:0] acc, rej;
  logic [3:0]  acc4, rej4;
`ifdef EX_TRIG_TIMESTAMP_EN
  logic [31:0] ts, ts4;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit done  = 1'b0;

  ex_trig_gate dut (
    .Clk(Clk), .Rst_N(Rst_N), .In_Ex_Trig(In_Ex_Trig), .In_Trig_En(In_Trig_En),
    .In_Busy(In_Busy), .In_Cnt_Clr(In_Cnt_Clr), .In_Trig_Id_Ready(In_Trig_Id_Ready),
    .Out_Asic_Trig(asic), .Out_Trig_Id(id), .Out_Trig_Id_Valid(valid),
    .Out_Acc_Cnt(acc), .Out_Rej_Cnt(rej)
`ifdef EX_TRIG_TIMESTAMP_EN
    , .Out_Trig_Tstamp(ts)
`endif
  );

  ex_trig_gate #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Rst_N(Rst_N), .In_Ex_Trig(In_Ex_Trig), .In_Trig_En(In_Trig_En),
    .In_Busy(In_Busy), .In_Cnt_Clr(In_Cnt_Clr), .In_Trig_Id_Ready(In_Trig_Id_Ready),
    .Out_Asic_Trig(asic4), .Out_Trig_Id(id4), .Out_Trig_Id_Valid(valid4),
    .Out_Acc_Cnt(acc4), .Out_Rej_Cnt(rej4)
`ifdef EX_TRIG_TIMESTAMP_EN
    , .Out_Trig_Tstamp(ts4)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the gate is "idle" again from a known cycle index, the pulse covers a known window.
  longint      m_cyc = 0;
  longint      m_last_acc, m_idle_from;
  logic        m_prev, m_valid;
  logic [15:0] m_id, m_next;
  logic [31:0] m_acc, m_rej, m_ts, m_tsl;
  logic [3:0]  m_acc4, m_rej4;
  logic        m_edge, m_accept, m_reject, m_asic;

  always_comb begin
    m_edge   = In_Ex_Trig & ~m_prev;
    m_accept = m_edge & In_Trig_En & ~In_Busy & (m_cyc >= m_idle_from) & ~m_valid & ~In_Cnt_Clr;
    m_reject = m_edge & In_Trig_En & ~In_Cnt_Clr & ~m_accept;
    m_asic   = (m_cyc >= m_last_acc + 1) && (m_cyc <= m_last_acc + P);
  end

  always @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      m_prev <= 1'b0; m_valid <= 1'b0; m_id <= 16'd0; m_next <= 16'd0;
      m_acc <= 32'd0; m_rej <= 32'd0; m_acc4 <= 4'd0; m_rej4 <= 4'd0;
      m_ts <= 32'd0; m_tsl <= 32'd0;
      m_last_acc <= -64'sd1000; m_idle_from <= 64'sd0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_prev <= In_Ex_Trig;
      if (m_accept) begin
        m_valid     <= 1'b1;
        m_id        <= m_next;
        m_last_acc  <= m_cyc;
        m_idle_from <= m_cyc + P + H + 1;
        m_tsl       <= m_ts;
      end else if (m_valid && In_Trig_Id_Ready) begin
        m_valid <= 1'b0;
      end
      m_next <= In_Cnt_Clr ? 16'd0 : (m_accept ? m_next + 16'd1 : m_next);
      m_ts   <= In_Cnt_Clr ? 32'd0 : m_ts + 32'd1;
      if (In_Cnt_Clr) begin
        m_acc <= 32'd0; m_rej <= 32'd0; m_acc4 <= 4'd0; m_rej4 <= 4'd0;
      end else begin
        if (m_accept && m_acc != 32'hFFFF_FFFF) m_acc <= m_acc + 32'd1;
        if (m_reject && m_rej != 32'hFFFF_FFFF) m_rej <= m_rej + 32'd1;
        if (m_accept && m_acc4 != 4'hF) m_acc4 <= m_acc4 + 4'd1;
        if (m_reject && m_rej4 != 4'hF) m_rej4 <= m_rej4 + 4'd1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clk) begin
    if (!done) begin
      check("asic", 64'(asic), 64'(m_asic));
      check("valid", 64'(valid), 64'(m_valid));
      check("id", 64'(id), 64'(m_id));
      check("acc", 64'(acc), 64'(m_acc));
      check("rej", 64'(rej), 64'(m_rej));
      check("asic4", 64'(asic4), 64'(m_asic));
      check("valid4", 64'(valid4), 64'(m_valid));
      check("id4", 64'(id4), 64'(m_id));
      check("acc4", 64'(acc4), 64'(m_acc4));
      check("rej4", 64'(rej4), 64'(m_rej4));
`ifdef EX_TRIG_TIMESTAMP_EN
      if (m_valid) check("tstamp", 64'(ts), 64'(m_tsl));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_N = 1'b0; In_Ex_Trig = 1'b0; In_Trig_En = 1'b1; In_Busy = 1'b0;
    In_Cnt_Clr = 1'b0; In_Trig_Id_Ready = 1'b1;
    tick(3);
    check("rst_asic", 64'(asic), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_acc", 64'(acc), 64'd0);
    check("rst_rej", 64'(rej), 64'd0);
    Rst_N = 1'b1;
    tick(5);

    // Basic accept: pulse 4 cycles, valid one cycle with ready high
    In_Ex_Trig = 1'b1; tick(1);
    check("t1_asic", 64'(asic), 64'd1);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_id", 64'(id), 64'd0);
    check("t1_acc", 64'(acc), 64'd1);
    tick(1);
    check("t1_valid_drop", 64'(valid), 64'd0);
    tick(3);
    check("t1_asic_end", 64'(asic), 64'd0);
    tick(2); In_Ex_Trig = 1'b0;

    // Edge during holdoff is rejected, later edge accepted
    tick(30);
    In_Ex_Trig = 1'b1; tick(1);
    check("t2_rej", 64'(rej), 64'd1);
    check("t2_asic", 64'(asic), 64'd0);
    In_Ex_Trig = 1'b0; tick(70);
    In_Ex_Trig = 1'b1; tick(1);
    check("t2_asic", 64'(asic), 64'd1);
    check("t2_id", 64'(id), 64'd1);
    check("t2_acc", 64'(acc), 64'd2);

    // Busy veto counts, disabled edge does not
    In_Ex_Trig = 1'b0; tick(100);
    In_Busy = 1'b1; In_Ex_Trig = 1'b1; tick(1);
    check("t3_busy_rej", 64'(rej), 64'd2);
    check("t3_busy_asic", 64'(asic), 64'd0);
    In_Ex_Trig = 1'b0; In_Busy = 1'b0; In_Trig_En = 1'b0; tick(1);
    In_Ex_Trig = 1'b1; tick(1);
    check("t3_dis_rej", 64'(rej), 64'd2);
    check("t3_dis_acc", 64'(acc), 64'd2);
    In_Ex_Trig = 1'b0; In_Trig_En = 1'b1; tick(1);

    // Pending ID blocks acceptance until handshake completes
    In_Trig_Id_Ready = 1'b0; In_Ex_Trig = 1'b1; tick(1);
    check("t4_valid", 64'(valid), 64'd1);
    check("t4_id", 64'(id), 64'd2);
    In_Ex_Trig = 1'b0; tick(120);
    check("t4_hold_valid", 64'(valid), 64'd1);
    check("t4_hold_id", 64'(id), 64'd2);
    In_Ex_Trig = 1'b1; tick(1);
    check("t4_blocked_rej", 64'(rej), 64'd3);
    In_Ex_Trig = 1'b0; tick(1);
    In_Trig_Id_Ready = 1'b1; tick(1);
    check("t4_valid_drop", 64'(valid), 64'd0);
    In_Ex_Trig = 1'b1; tick(1);
    check("t4_id2", 64'(id), 64'd3);
    check("t4_acc", 64'(acc), 64'd4);
    In_Ex_Trig = 1'b0; tick(100);

    // Asynchronous reset in the middle of a pulse
    In_Ex_Trig = 1'b1; tick(2);
    #2 Rst_N = 1'b0;
    #1;
    check("t5_rst_asic", 64'(asic), 64'd0);
    check("t5_rst_valid", 64'(valid), 64'd0);
    check("t5_rst_acc", 64'(acc), 64'd0);
    In_Ex_Trig = 1'b0; tick(2);
    Rst_N = 1'b1;
    tick(5);
    In_Ex_Trig = 1'b1; tick(1);
    check("t5_id", 64'(id), 64'd0);
    check("t5_acc", 64'(acc), 64'd1);
`ifdef EX_TRIG_TIMESTAMP_EN
    check("t5_tstamp", 64'(ts), 64'd5);
`endif
    In_Ex_Trig = 1'b0; tick(1);

    // Saturation of the narrow counter, then clear
    In_Busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      In_Ex_Trig = 1'b1; tick(1);
      In_Ex_Trig = 1'b0; tick(1);
    end
    check("t6_rej4_sat", 64'(rej4), 64'd15);
    check("t6_rej", 64'(rej), 64'd20);
    In_Cnt_Clr = 1'b1; tick(1);
    In_Cnt_Clr = 1'b0;
    check("t6_rej4_clr", 64'(rej4), 64'd0);
    check("t6_acc_clr", 64'(acc), 64'd0);
    In_Busy = 1'b0; tick(100);
    In_Ex_Trig = 1'b1; tick(1);
    check("t6_id", 64'(id), 64'd0);
    check("t6_acc", 64'(acc), 64'd1);
    In_Ex_Trig = 1'b0; tick(20);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_trig_gate.md
Name: ex_trig_gate

Overview:
Downstream consumer of the external-trigger pulse stretcher: takes its stretched trigger pulse (about 7 clk high) and decides whether to issue a trigger to the ASIC readout.
- Applies run-enable, readout-busy veto and a post-trigger holdoff.
- Emits a fixed-width ASIC trigger pulse.
- Hands a trigger ID to the data packer over a valid/ready handshake.
- Keeps saturating accepted/rejected trigger counters for slow control.

Parameters:
PULSE_CYCLES, 4, width of Out_Asic_Trig in clk cycles (legal range 1..255).
HOLDOFF_CYCLES, 80, dead time after the pulse ends (80 = 1 us at 12.5 ns clk); 0 means no holdoff state.
ID_W, 16, trigger ID width; the ID wraps modulo 2^ID_W.
CNT_W, 32, width of each accepted/rejected counter; counters saturate.

Ports:
Clk  in  1  system clock, one domain
Rst_N  in  1  asynchronous active-low reset
In_Ex_Trig  in  1  stretched trigger from upstream stage, synchronous to Clk
In_Trig_En  in  1  run enable (level)
In_Busy  in  1  readout busy veto (level)
In_Cnt_Clr  in  1  synchronous clear of counters and trigger ID (single-cycle pulse)
In_Trig_Id_Ready  in  1  packer ready
Out_Asic_Trig  out  1  trigger pulse to ASIC
Out_Trig_Id  out  ID_W  ID of the accepted trigger
Out_Trig_Id_Valid  out  1  ID valid
Out_Acc_Cnt  out  CNT_W  accepted triggers
Out_Rej_Cnt  out  CNT_W  rejected triggers
Out_Trig_Tstamp  out  32  only when EX_TRIG_TIMESTAMP_EN is defined

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): all outputs 0; state IDLE; next ID 0; edge register 0.
- Edge detect: Trig_Q <= In_Ex_Trig. Edge = In_Ex_Trig & ~Trig_Q. Only the rising edge matters; pulse length is irrelevant.
- Accept condition: Edge & In_Trig_En & ~In_Busy & state==IDLE & ~Out_Trig_Id_Valid & ~In_Cnt_Clr.
- Reject condition: Edge & In_Trig_En & ~In_Cnt_Clr & not accept.
  - An edge while In_Trig_En=0 is neither accepted nor counted.
  - An edge in the same cycle as In_Cnt_Clr is ignored.
- On accept in cycle N:
  - Out_Asic_Trig is high for cycles N+1 .. N+PULSE_CYCLES.
  - Out_Trig_Id_Valid rises at N+1, with Out_Trig_Id = next ID.
  - Next ID increments (wraps).
  - Out_Acc_Cnt increments (saturates at all-ones); visible at N+1.
- On reject: Out_Rej_Cnt increments (saturates); visible the next cycle.
- FSM:
  - IDLE -> PULSE on accept.
  - PULSE lasts PULSE_CYCLES cycles, then goes to HOLDOFF, or to IDLE when HOLDOFF_CYCLES=0.
  - HOLDOFF lasts HOLDOFF_CYCLES cycles, then IDLE.
  - One down-counter of 16 bits or more serves both timed states.
- Deasserting In_Trig_En or asserting In_Busy during PULSE/HOLDOFF does not shorten either state.
- Handshake:
  - Valid holds, with ID stable, until the cycle where In_Trig_Id_Ready=1; valid drops the following cycle.
  - Ready may be held high permanently.
  - An ID still pending blocks acceptance, which gives at most one ID outstanding.
- In_Cnt_Clr: zeroes both counters and next ID on the next edge. It does not affect the FSM or a pending valid/ID.

Optional Feature:
EX_TRIG_TIMESTAMP_EN:
- Defined:
  - A free-running 32-bit counter (reset 0, wraps) is added.
  - Its value in accept cycle N is latched and driven on Out_Trig_Tstamp.
  - Out_Trig_Tstamp is qualified by Out_Trig_Id_Valid and stable under the same handshake.
  - In_Cnt_Clr also zeroes the timestamp counter.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package ex_trig_pkg:
  - FSM state enum (IDLE, PULSE, HOLDOFF).
  - Default constants for PULSE_CYCLES, HOLDOFF_CYCLES, ID_W, CNT_W.
  - Timestamp width constant 32.
- Sub-module sat_counter (parameter W; inputs inc and clr; output cnt; saturates at all-ones), instantiated twice for the accepted and rejected counters.

Test Plan:
1. Defaults, En=1, Busy=0, Ready=1; In_Ex_Trig high cycles 10-16 -> Out_Asic_Trig high cycles 11-14; Valid high cycle 11 only, Id=0; Acc=1, Rej=0.
2. After 1, a new edge at cycle 50 (HOLDOFF spans 15-94) -> no pulse, Rej=1. Edge at cycle 100 -> pulse 101-104, Id=1, Acc=2.
3. Busy=1, edge -> Rej+1, no pulse. En=0, edge -> both counters unchanged.
4. Ready=0; accept at cycle 10 -> Valid stays high with Id=0. Edge at cycle 200 -> rejected. Ready=1 at cycle 210 -> Valid low at 211. Edge at cycle 220 -> accepted, Id=1.
5. Rst_N low during cycle 12 of a pulse -> Out_Asic_Trig, Valid and counters 0 immediately. After release, first edge -> Id=0, Acc=1.
6. CNT_W=4; 20 rejected edges -> Rej=15 and holds. In_Cnt_Clr -> Rej=0, next accepted Id=0. With EX_TRIG_TIMESTAMP_EN, accept 5 cycles after reset release -> Tstamp=5.
